// File: rtl/ex_stage_md.sv
// MIPS execute stage: ALU, iterative multiply/divide with HI/LO, sized
// loads/stores with byte enables, misalignment detection and flush.
module ex_stage_md #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            es_flush,
  input  logic            ms_allowin,
  output logic            es_allowin,
  input  logic            ds_to_es_valid,
  input  logic [11:0]     ds_alu_op,
  input  logic [XLEN-1:0] ds_src1,
  input  logic [XLEN-1:0] ds_src2,
  input  logic [XLEN-1:0] ds_rt_data,
  input  logic [2:0]      ds_md_op,
  input  logic [3:0]      ds_mem_op,
  input  logic [1:0]      ds_res_sel,
  input  logic            ds_rf_we,
  input  logic [4:0]      ds_rf_waddr,
  input  logic [XLEN-1:0] ds_pc,
  output logic            es_to_ms_valid,
  output logic [XLEN-1:0] es_to_ms_pc,
  output logic [XLEN-1:0] es_to_ms_result,
  output logic [3:0]      es_to_ms_mem_op,
  output logic            es_to_ms_rf_we,
  output logic [4:0]      es_to_ms_rf_waddr,
  output logic            es_to_ms_addr_err,
  output logic            cpu_data_en,
  output logic [3:0]      cpu_data_wen,
  output logic [31:0]     cpu_data_addr,
  output logic [31:0]     cpu_data_wdata,
  output logic            es_valid,
  output logic [4:0]      es_rf_waddr
);
  localparam int SHW  = (XLEN == 64) ? 6 : 5;
  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef struct packed {
    logic [11:0]     alu_op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [XLEN-1:0] rt;
    logic [2:0]      md_op;
    logic [3:0]      mem_op;
    logic [1:0]      res_sel;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] pc;
  } es_req_t;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

  logic            r_es_valid;
  es_req_t         r_req, w_ds_req;
  md_state_e       r_md_state, w_md_next;
  logic [CW-1:0]   r_md_cnt, w_md_cnt_nxt, w_cyc;
  logic [XLEN-1:0] r_hi, r_lo, r_acc_hi, r_acc_lo, r_dvs;

  assign w_ds_req = '{alu_op: ds_alu_op, src1: ds_src1, src2: ds_src2, rt: ds_rt_data,
                      md_op: ds_md_op, mem_op: ds_mem_op, res_sel: ds_res_sel,
                      rf_we: ds_rf_we, rf_waddr: ds_rf_waddr, pc: ds_pc};

  logic w_is_md, w_is_mul, w_signed, w_ready_go, w_leave, w_md_start;
  assign w_is_md    = (r_req.md_op >= 3'd1) && (r_req.md_op <= 3'd4);
  assign w_is_mul   = (r_req.md_op == 3'd1) || (r_req.md_op == 3'd2);
  assign w_signed   = (r_req.md_op == 3'd1) || (r_req.md_op == 3'd3);
  assign w_ready_go = ~(r_es_valid & w_is_md) | (r_md_state == MD_DONE);
  assign es_allowin     = ~r_es_valid | (w_ready_go & ms_allowin);
  assign es_to_ms_valid = r_es_valid & w_ready_go & ~es_flush;
  assign w_leave        = es_to_ms_valid & ms_allowin;
  assign w_md_start     = r_es_valid & w_is_md & (r_md_state == MD_IDLE) & ~es_flush;
  assign w_cyc          = w_is_mul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);

  always_ff @(posedge clk) begin
    if (!reset)              r_es_valid <= 1'b0;
    else if (es_flush)       r_es_valid <= 1'b0;
    else if (es_allowin)     r_es_valid <= ds_to_es_valid;
  end

  always_ff @(posedge clk) begin
    if (es_allowin && ds_to_es_valid) r_req <= w_ds_req;
  end

  // The capture cycle counts as the first MD cycle, so BUSY lasts cycles-1.
  always_comb begin
    w_md_next    = r_md_state;
    w_md_cnt_nxt = r_md_cnt;
    case (r_md_state)
      MD_IDLE: if (w_md_start) begin
        w_md_cnt_nxt = w_cyc - CW'(1);
        w_md_next    = (w_cyc == CW'(1)) ? MD_DONE : MD_BUSY;
      end
      MD_BUSY: begin
        w_md_cnt_nxt = r_md_cnt - CW'(1);
        if (r_md_cnt == CW'(1)) w_md_next = MD_DONE;
      end
      MD_DONE: if (es_allowin) w_md_next = MD_IDLE;
      default: w_md_next = MD_IDLE;
    endcase
    if (es_flush) begin
      w_md_next    = MD_IDLE;
      w_md_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_md_state <= MD_IDLE;
      r_md_cnt   <= '0;
    end else begin
      r_md_state <= w_md_next;
      r_md_cnt   <= w_md_cnt_nxt;
    end
  end

  // Operand magnitudes; signed ops work on |x| and fix signs at the end.
  logic [XLEN-1:0] w_a, w_b, w_a_abs, w_b_abs;
  logic            w_a_neg, w_b_neg;
  assign w_a     = r_req.src1;
  assign w_b     = r_req.src2;
  assign w_a_neg = w_signed & w_a[XLEN-1];
  assign w_b_neg = w_signed & w_b[XLEN-1];
  assign w_a_abs = w_a_neg ? -w_a : w_a;
  assign w_b_abs = w_b_neg ? -w_b : w_b;

  logic [2*XLEN-1:0] w_prod;
  assign w_prod = {{XLEN{w_a_neg}}, w_a} * {{XLEN{w_b_neg}}, w_b};

  logic [XLEN-1:0] w_st_rem, w_st_quo, w_st_dvs, w_rem_nxt, w_quo_nxt;
  logic [XLEN:0]   w_sh, w_diff;
  assign w_st_rem  = w_md_start ? '0 : r_acc_hi;
  assign w_st_quo  = w_md_start ? w_a_abs : r_acc_lo;
  assign w_st_dvs  = w_md_start ? w_b_abs : r_dvs;
  assign w_sh      = {w_st_rem, w_st_quo[XLEN-1]};
  assign w_diff    = w_sh - {1'b0, w_st_dvs};
  assign w_rem_nxt = w_diff[XLEN] ? w_sh[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_quo_nxt = {w_st_quo[XLEN-2:0], ~w_diff[XLEN]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_dvs    <= '0;
    end else if (w_md_start) begin
      r_dvs <= w_b_abs;
      if (w_is_mul) {r_acc_hi, r_acc_lo} <= w_prod;
      else          {r_acc_hi, r_acc_lo} <= {w_rem_nxt, w_quo_nxt};
    end else if (r_md_state == MD_BUSY && !w_is_mul && !es_flush) begin
      {r_acc_hi, r_acc_lo} <= {w_rem_nxt, w_quo_nxt};
    end
  end

  logic [XLEN-1:0] w_md_hi, w_md_lo;
  logic            w_div_zero;
  assign w_div_zero = (w_b == '0);
  assign w_md_hi = w_is_mul ? r_acc_hi : w_div_zero ? w_a : (w_a_neg ? -r_acc_hi : r_acc_hi);
  assign w_md_lo = w_is_mul ? r_acc_lo : w_div_zero ? '1
                 : ((w_a_neg ^ w_b_neg) ? -r_acc_lo : r_acc_lo);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_leave && r_md_state == MD_DONE) begin
      r_hi <= w_md_hi;
      r_lo <= w_md_lo;
    end else if (w_leave && r_req.md_op == 3'd5) begin
      r_hi <= w_a;
    end else if (w_leave && r_req.md_op == 3'd6) begin
      r_lo <= w_a;
    end
  end

  logic [SHW-1:0]  w_sa;
  logic [XLEN-1:0] w_alu, w_slt, w_sltu, w_sra, w_lui;
  logic [11:0]     w_op;
  assign w_op   = r_req.alu_op;
  assign w_sa   = w_a[SHW-1:0];
  assign w_slt  = {{(XLEN-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
  assign w_sltu = {{(XLEN-1){1'b0}}, (w_a < w_b)};
  assign w_sra  = XLEN'($signed(w_b) >>> w_sa);
  assign w_lui  = {{(XLEN-16){w_b[15]}}, w_b[15:0]} << 16;
  assign w_alu  = ({XLEN{w_op[0]}}  & (w_a + w_b))  | ({XLEN{w_op[1]}}  & (w_a - w_b))
                | ({XLEN{w_op[2]}}  & w_slt)        | ({XLEN{w_op[3]}}  & w_sltu)
                | ({XLEN{w_op[4]}}  & (w_a & w_b))  | ({XLEN{w_op[5]}}  & ~(w_a | w_b))
                | ({XLEN{w_op[6]}}  & (w_a | w_b))  | ({XLEN{w_op[7]}}  & (w_a ^ w_b))
                | ({XLEN{w_op[8]}}  & (w_b << w_sa)) | ({XLEN{w_op[9]}} & (w_b >> w_sa))
                | ({XLEN{w_op[10]}} & w_sra)        | ({XLEN{w_op[11]}} & w_lui);

  logic [31:0] w_addr;
  logic [3:0]  w_mem;
  logic        w_is_store, w_addr_err;
  assign w_addr     = w_alu[31:0];
  assign w_mem      = r_req.mem_op;
  assign w_is_store = w_mem[3];
  assign w_addr_err = (((w_mem == 4'd3) | (w_mem == 4'd4) | (w_mem == 4'd10)) & w_addr[0])
                    | (((w_mem == 4'd5) | (w_mem == 4'd11)) & (w_addr[1:0] != 2'b00));

  // Request only on the accept cycle so a stalled access is never reissued.
  assign cpu_data_en    = w_leave & (w_mem != 4'd0) & ~w_addr_err;
  assign cpu_data_addr  = w_addr;

  always_comb begin
    cpu_data_wen   = 4'b0000;
    cpu_data_wdata = r_req.rt[31:0];
    case (w_mem)
      4'd9:  cpu_data_wdata = {4{r_req.rt[7:0]}};
      4'd10: cpu_data_wdata = {2{r_req.rt[15:0]}};
      default: ;
    endcase
    if (cpu_data_en && w_is_store) begin
      case (w_mem)
        4'd9:    cpu_data_wen = 4'b0001 << w_addr[1:0];
        4'd10:   cpu_data_wen = 4'b0011 << w_addr[1:0];
        4'd11:   cpu_data_wen = 4'b1111;
        default: cpu_data_wen = 4'b0000;
      endcase
    end
  end

  assign es_valid          = r_es_valid;
  assign es_rf_waddr       = r_req.rf_waddr;
  assign es_to_ms_pc       = r_req.pc;
  assign es_to_ms_result   = (r_req.res_sel == 2'd1) ? r_hi
                           : (r_req.res_sel == 2'd2) ? r_lo : w_alu;
  assign es_to_ms_mem_op   = (w_addr_err & w_is_store) ? 4'd0 : w_mem;
  assign es_to_ms_rf_we    = r_req.rf_we & ~w_addr_err;
  assign es_to_ms_rf_waddr = r_req.rf_waddr;
  assign es_to_ms_addr_err = w_addr_err;
endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: ALU, MD timing/results, stores, flush, back-pressure.
module tb_ex_stage_md;
  localparam logic [11:0] OP_ADD = 12'h001, OP_SUB = 12'h002, OP_SLT = 12'h004,
    OP_SLTU = 12'h008, OP_AND = 12'h010, OP_NOR = 12'h020, OP_OR = 12'h040,
    OP_XOR = 12'h080, OP_SLL = 12'h100, OP_SRL = 12'h200, OP_SRA = 12'h400,
    OP_LUI = 12'h800;

  logic        clk = 1'b0, reset, es_flush, ms_allowin, es_allowin, ds_to_es_valid;
  logic [11:0] ds_alu_op;
  logic [31:0] ds_src1, ds_src2, ds_rt_data, ds_pc;
  logic [2:0]  ds_md_op;
  logic [3:0]  ds_mem_op, es_to_ms_mem_op, cpu_data_wen;
  logic [1:0]  ds_res_sel;
  logic        ds_rf_we, es_to_ms_valid, es_to_ms_rf_we, es_to_ms_addr_err, cpu_data_en, es_valid;
  logic [4:0]  ds_rf_waddr, es_to_ms_rf_waddr, es_rf_waddr;
  logic [31:0] es_to_ms_pc, es_to_ms_result, cpu_data_addr, cpu_data_wdata;

  int n_assert = 0, n_fail = 0;
  int st;

  ex_stage_md #(.XLEN(32), .MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .reset(reset), .es_flush(es_flush), .ms_allowin(ms_allowin),
    .es_allowin(es_allowin), .ds_to_es_valid(ds_to_es_valid), .ds_alu_op(ds_alu_op),
    .ds_src1(ds_src1), .ds_src2(ds_src2), .ds_rt_data(ds_rt_data), .ds_md_op(ds_md_op),
    .ds_mem_op(ds_mem_op), .ds_res_sel(ds_res_sel), .ds_rf_we(ds_rf_we),
    .ds_rf_waddr(ds_rf_waddr), .ds_pc(ds_pc), .es_to_ms_valid(es_to_ms_valid),
    .es_to_ms_pc(es_to_ms_pc), .es_to_ms_result(es_to_ms_result),
    .es_to_ms_mem_op(es_to_ms_mem_op), .es_to_ms_rf_we(es_to_ms_rf_we),
    .es_to_ms_rf_waddr(es_to_ms_rf_waddr), .es_to_ms_addr_err(es_to_ms_addr_err),
    .cpu_data_en(cpu_data_en), .cpu_data_wen(cpu_data_wen), .cpu_data_addr(cpu_data_addr),
    .cpu_data_wdata(cpu_data_wdata), .es_valid(es_valid), .es_rf_waddr(es_rf_waddr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [11:0] op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] rt, input logic [2:0] md, input logic [3:0] mem,
                       input logic [1:0] rsel, input logic we, input logic [4:0] wa,
                       input logic [31:0] pc);
    ds_alu_op = op; ds_src1 = s1; ds_src2 = s2; ds_rt_data = rt; ds_md_op = md;
    ds_mem_op = mem; ds_res_sel = rsel; ds_rf_we = we; ds_rf_waddr = wa; ds_pc = pc;
    ds_to_es_valid = 1'b1;
  endtask

  task automatic alu_chk(input string tag, input logic [11:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    issue(op, a, b, 32'h0, 3'd0, 4'd0, 2'd0, 1'b1, 5'd3, 32'h100);
    tick;
    ds_to_es_valid = 1'b0;
    #1;
    check(tag, 64'(es_to_ms_result), 64'(exp));
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
    issue(OP_ADD, 32'h0, 32'h0, 32'h0, 3'd0, 4'd0, 2'd1, 1'b1, 5'd2, 32'h200);
    tick;
    issue(OP_ADD, 32'h0, 32'h0, 32'h0, 3'd0, 4'd0, 2'd2, 1'b1, 5'd2, 32'h204);
    #1;
    check({tag, "_hi"}, 64'(es_to_ms_result), 64'(ehi));
    tick;
    ds_to_es_valid = 1'b0;
    #1;
    check({tag, "_lo"}, 64'(es_to_ms_result), 64'(elo));
    tick;
  endtask

  // Issues an MD op, counts cycles with es_allowin low, then lets it retire.
  task automatic run_md(input logic [2:0] md, input logic [31:0] a, input logic [31:0] b,
                        output int stall);
    issue(OP_ADD, a, b, 32'h0, md, 4'd0, 2'd0, 1'b0, 5'd0, 32'h300);
    tick;
    ds_to_es_valid = 1'b0;
    stall = 0;
    while (es_allowin !== 1'b1 && stall < 100) begin
      stall++;
      tick;
    end
    tick;
  endtask

  initial begin
    reset = 1'b0; es_flush = 1'b0; ms_allowin = 1'b1;
    issue(OP_ADD, 32'h1, 32'h2, 32'h0, 3'd0, 4'd11, 2'd0, 1'b1, 5'd1, 32'h0);
    tick; tick;
    check("rst_es_valid", 64'(es_valid), 64'(0));
    check("rst_to_ms_valid", 64'(es_to_ms_valid), 64'(0));
    check("rst_wen", 64'(cpu_data_wen), 64'(0));
    check("rst_data_en", 64'(cpu_data_en), 64'(0));
    ds_to_es_valid = 1'b0;
    reset = 1'b1;
    read_hilo("rst", 32'h0, 32'h0);

    alu_chk("add",  OP_ADD,  32'h5,        32'h7,        32'hC);
    alu_chk("sub",  OP_SUB,  32'h5,        32'h7,        32'hFFFF_FFFE);
    alu_chk("slt",  OP_SLT,  32'hFFFF_FFFF, 32'h1,       32'h1);
    alu_chk("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1,       32'h0);
    alu_chk("and",  OP_AND,  32'hF0F0,     32'hFF00,     32'hF000);
    alu_chk("nor",  OP_NOR,  32'h0,        32'h0,        32'hFFFF_FFFF);
    alu_chk("or",   OP_OR,   32'hF0,       32'h0F,       32'hFF);
    alu_chk("xor",  OP_XOR,  32'hFF,       32'h0F,       32'hF0);
    alu_chk("sll",  OP_SLL,  32'h24,       32'h1,        32'h10);
    alu_chk("srl",  OP_SRL,  32'h4,        32'h8000_0000, 32'h0800_0000);
    alu_chk("sra",  OP_SRA,  32'h4,        32'h8000_0000, 32'hF800_0000);
    alu_chk("lui",  OP_LUI,  32'h0,        32'h1234,     32'h1234_0000);
    check("alu_waddr", 64'(es_to_ms_rf_waddr), 64'(3));
    check("alu_rf_we", 64'(es_to_ms_rf_we), 64'(1));
    tick;

    // mult -2 * 3 followed directly by mflo waiting in ID
    issue(OP_ADD, 32'hFFFF_FFFE, 32'h3, 32'h0, 3'd1, 4'd0, 2'd0, 1'b0, 5'd0, 32'h300);
    tick;
    issue(OP_ADD, 32'h0, 32'h0, 32'h0, 3'd0, 4'd0, 2'd2, 1'b1, 5'd4, 32'h304);
    st = 0;
    while (es_allowin !== 1'b1 && st < 100) begin
      st++;
      tick;
    end
    check("mult_stall", 64'(st), 64'(4));
    check("mult_done_valid", 64'(es_to_ms_valid), 64'(1));
    tick;
    ds_to_es_valid = 1'b0;
    #1;
    check("mflo_after_mult", 64'(es_to_ms_result), 64'hFFFF_FFFA);
    tick;
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    run_md(3'd2, 32'hFFFF_FFFE, 32'h3, st);
    read_hilo("multu", 32'h2, 32'hFFFF_FFFA);
    run_md(3'd4, 32'h7, 32'h0, st);
    check("div_stall", 64'(st), 64'(32));
    read_hilo("divu_by0", 32'h7, 32'hFFFF_FFFF);
    run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, st);
    read_hilo("div_min", 32'h0, 32'h8000_0000);
    run_md(3'd3, 32'hFFFF_FFF9, 32'h2, st);
    read_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(OP_ADD, 32'h11, 32'h0, 32'h0, 3'd5, 4'd0, 2'd0, 1'b0, 5'd0, 32'h400);
    tick;
    issue(OP_ADD, 32'h22, 32'h0, 32'h0, 3'd6, 4'd0, 2'd0, 1'b0, 5'd0, 32'h404);
    tick;
    ds_to_es_valid = 1'b0;
    tick;
    read_hilo("mthilo", 32'h11, 32'h22);

    // flush on cycle 5 of a divide
    issue(OP_ADD, 32'd100, 32'd7, 32'h0, 3'd4, 4'd0, 2'd0, 1'b0, 5'd0, 32'h500);
    tick;
    ds_to_es_valid = 1'b0;
    tick; tick; tick; tick;
    es_flush = 1'b1;
    #1;
    check("flush_to_ms_valid", 64'(es_to_ms_valid), 64'(0));
    tick;
    es_flush = 1'b0;
    #1;
    check("flush_es_valid", 64'(es_valid), 64'(0));
    check("flush_allowin", 64'(es_allowin), 64'(1));
    alu_chk("post_flush_add", OP_ADD, 32'h1, 32'h2, 32'h3);
    check("post_flush_go", 64'(es_allowin), 64'(1));
    tick;
    read_hilo("flush", 32'h11, 32'h22);
    run_md(3'd2, 32'h5, 32'h6, st);
    check("post_flush_mul_stall", 64'(st), 64'(4));
    read_hilo("post_flush_mul", 32'h0, 32'd30);

    // stores and misalignment
    issue(OP_ADD, 32'h1000, 32'h3, 32'hAB, 3'd0, 4'd9, 2'd0, 1'b0, 5'd0, 32'h600);
    tick; ds_to_es_valid = 1'b0; #1;
    check("sb_en", 64'(cpu_data_en), 64'(1));
    check("sb_wen", 64'(cpu_data_wen), 64'(4'b1000));
    check("sb_wdata", 64'(cpu_data_wdata), 64'hABAB_ABAB);
    check("sb_addr", 64'(cpu_data_addr), 64'h1003);
    tick;
    issue(OP_ADD, 32'h1000, 32'h2, 32'h1234, 3'd0, 4'd10, 2'd0, 1'b0, 5'd0, 32'h604);
    tick; ds_to_es_valid = 1'b0; #1;
    check("sh_wen", 64'(cpu_data_wen), 64'(4'b1100));
    check("sh_wdata", 64'(cpu_data_wdata), 64'h1234_1234);
    tick;
    issue(OP_ADD, 32'h1000, 32'h2, 32'h55, 3'd0, 4'd11, 2'd0, 1'b0, 5'd0, 32'h608);
    tick; ds_to_es_valid = 1'b0; #1;
    check("sw_mis_err", 64'(es_to_ms_addr_err), 64'(1));
    check("sw_mis_wen", 64'(cpu_data_wen), 64'(0));
    check("sw_mis_en", 64'(cpu_data_en), 64'(0));
    check("sw_mis_memop", 64'(es_to_ms_mem_op), 64'(0));
    tick;
    issue(OP_ADD, 32'h1000, 32'h1, 32'h0, 3'd0, 4'd3, 2'd0, 1'b1, 5'd8, 32'h60C);
    tick; ds_to_es_valid = 1'b0; #1;
    check("lh_mis_err", 64'(es_to_ms_addr_err), 64'(1));
    check("lh_mis_rf_we", 64'(es_to_ms_rf_we), 64'(0));
    check("lh_mis_en", 64'(cpu_data_en), 64'(0));
    check("lh_mis_memop", 64'(es_to_ms_mem_op), 64'(3));
    tick;

    // back-pressure on a lw, with a younger add waiting in ID
    ms_allowin = 1'b0;
    issue(OP_ADD, 32'h2000, 32'h0, 32'h0, 3'd0, 4'd5, 2'd0, 1'b1, 5'd5, 32'h700);
    tick;
    issue(OP_ADD, 32'h30, 32'h1, 32'h0, 3'd0, 4'd0, 2'd0, 1'b1, 5'd7, 32'h704);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_allowin", 64'(es_allowin), 64'(0));
      check("bp_en", 64'(cpu_data_en), 64'(0));
      check("bp_result", 64'(es_to_ms_result), 64'h2000);
      check("bp_pc", 64'(es_to_ms_pc), 64'h700);
      check("bp_waddr", 64'(es_rf_waddr), 64'(5));
      check("bp_to_ms_valid", 64'(es_to_ms_valid), 64'(1));
      tick;
    end
    ms_allowin = 1'b1;
    #1;
    check("bp_accept_en", 64'(cpu_data_en), 64'(1));
    check("bp_accept_allowin", 64'(es_allowin), 64'(1));
    tick;
    ds_to_es_valid = 1'b0;
    #1;
    check("bp_next_result", 64'(es_to_ms_result), 64'h31);
    check("bp_next_waddr", 64'(es_to_ms_rf_waddr), 64'(7));
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
